// File: rtl/carry_save_resolver.sv
// carry_save_resolver: resolves a half-adder (sum, carry) pair to a binary sum one step per clock; in_* handshake accepts, out_* handshake delivers result/overflow/iterations
module carry_save_resolver #(
  parameter int WORD_WIDTH = 8,
  localparam int COUNT_WIDTH = $clog2(WORD_WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WORD_WIDTH-1:0]  in_sum,
  input  logic [WORD_WIDTH-1:0]  in_carry,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WORD_WIDTH-1:0]  out_result,
  output logic                   out_overflow,
  output logic [COUNT_WIDTH-1:0] out_iterations,
  output logic                   out_valid,
  input  logic                   out_ready
);
  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] s_q, s_d, c_q, c_d, res_q, res_d, cs;
  logic ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] iter_q, iter_d;
  assign cs = c_q << 1;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_result = res_q;
  assign out_overflow = ovf_q;
  assign out_iterations = iter_q;
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    c_d = c_q;
    res_d = res_q;
    ovf_d = ovf_q;
    iter_d = iter_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = RESOLVE;
        s_d = in_sum;
        c_d = in_carry;
        ovf_d = 1'b0;
        iter_d = '0;
      end
      RESOLVE: if (c_q == '0) begin
        state_d = DONE;
        res_d = s_q;
      end else begin
        ovf_d = ovf_q | c_q[WORD_WIDTH-1];
        s_d = s_q ^ cs;
        c_d = s_q & cs;
        iter_d = iter_q + COUNT_WIDTH'(1);
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s_q <= '0;
      c_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      iter_q <= '0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      c_q <= c_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      iter_q <= iter_d;
    end
  end
endmodule
